// File: rtl/motoro3_pkg.sv
// Shared definitions for the motoro3 gate-drive monitor: phase states,
// commutation sector constants and the six-step pattern decoder.
package motoro3_pkg;

  // Encoding is {H, L}, so the decoder maps raw gate pins straight through.
  typedef enum logic [1:0] {
    PH_LO    = 2'b00,
    PH_FLOAT = 2'b01,
    PH_SHOOT = 2'b10,
    PH_HI    = 2'b11
  } phase_e;

  localparam logic [2:0] SEC_0 = 3'd0;
  localparam logic [2:0] SEC_1 = 3'd1;
  localparam logic [2:0] SEC_2 = 3'd2;
  localparam logic [2:0] SEC_3 = 3'd3;
  localparam logic [2:0] SEC_4 = 3'd4;
  localparam logic [2:0] SEC_5 = 3'd5;

  typedef struct packed {
    logic       valid;
    logic [2:0] sec;
  } sec_dec_t;

  // A pattern is valid only with exactly one HI, one LO and the third phase floating.
  function automatic sec_dec_t decode_sector(input phase_e a, input phase_e b, input phase_e c);
    sec_dec_t r;
    r = '{valid: 1'b0, sec: SEC_0};
    case ({a, b, c})
      {PH_HI,    PH_LO,    PH_FLOAT}: r = '{valid: 1'b1, sec: SEC_0};
      {PH_HI,    PH_FLOAT, PH_LO   }: r = '{valid: 1'b1, sec: SEC_1};
      {PH_FLOAT, PH_HI,    PH_LO   }: r = '{valid: 1'b1, sec: SEC_2};
      {PH_LO,    PH_HI,    PH_FLOAT}: r = '{valid: 1'b1, sec: SEC_3};
      {PH_LO,    PH_FLOAT, PH_HI   }: r = '{valid: 1'b1, sec: SEC_4};
      {PH_FLOAT, PH_LO,    PH_HI   }: r = '{valid: 1'b1, sec: SEC_5};
      default:                        r = '{valid: 1'b0, sec: SEC_0};
    endcase
    return r;
  endfunction

  // Next sector in forward rotation, wrapping 5 -> 0.
  function automatic logic [2:0] sec_fwd(input logic [2:0] s);
    return (s >= SEC_5) ? SEC_0 : (s + 3'd1);
  endfunction

  // Next sector in reverse rotation, wrapping 0 -> 5.
  function automatic logic [2:0] sec_rev(input logic [2:0] s);
    return (s == SEC_0) ? SEC_5 : (s - 3'd1);
  endfunction

endpackage

// File: rtl/motoro3_phase_decode.sv
// Classifies one half-bridge from its high-side (active-high) and
// low-side (active-low) gate drives.
module motoro3_phase_decode
  import motoro3_pkg::*;
(
  input  logic   gate_h,
  input  logic   gate_l,
  output phase_e state
);

  // Map the gate pair to HI / LO / FLOAT / SHOOT.
  always_comb begin
    state = PH_FLOAT;
    case ({gate_h, gate_l})
      2'b11:   state = PH_HI;
      2'b00:   state = PH_LO;
      2'b01:   state = PH_FLOAT;
      2'b10:   state = PH_SHOOT;
      default: state = PH_FLOAT;
    endcase
  end

endmodule

// File: rtl/motoro3_gate_monitor.sv
// BLDC gate-drive monitor: samples the six gate signals, deglitches the
// commutation pattern, tracks sector/direction/step period and raises
// sticky shoot-through, illegal-pattern and skipped-sector faults.
module motoro3_gate_monitor
  import motoro3_pkg::*;
#(
  parameter int PERIOD_W = 20,
  parameter int DEGLITCH = 2
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic                aH,
  input  logic                bH,
  input  logic                cH,
  input  logic                aL,
  input  logic                bL,
  input  logic                cL,
  input  logic                fltClr,
  output logic [2:0]          sector,
  output logic                sectorValid,
  output logic                dir,
  output logic                stepStrobe,
  output logic [PERIOD_W-1:0] stepPeriod,
  output logic                pwmOn,
  output logic                stall,
  output logic                fltShoot,
  output logic                fltIllegal,
  output logic                fltSkip
);

  localparam logic [3:0]          DG_TH   = 4'(DEGLITCH);
  localparam logic [3:0]          DG_MAX  = 4'hF;
  localparam logic [PERIOD_W-1:0] PER_MAX = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] PER_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

  // Registered gate sample, {aH, aL, bH, bL, cH, cL}.
  logic [5:0]          gate_d, gate_q;
  logic [5:0]          last_key_d, last_key_q;
  logic [3:0]          dg_cnt_d, dg_cnt_q;
  logic [2:0]          sector_d, sector_q;
  logic                valid_d, valid_q;
  logic                dir_d, dir_q;
  logic                strobe_d, strobe_q;
  logic [PERIOD_W-1:0] period_d, period_q;
  logic [PERIOD_W-1:0] per_cnt_d, per_cnt_q;
  logic                pwm_on_d, pwm_on_q;
  logic                stall_d, stall_q;
  logic                flt_shoot_d, flt_shoot_q;
  logic                flt_illegal_d, flt_illegal_q;
  logic                flt_skip_d, flt_skip_q;

  phase_e   ph_a_s, ph_b_s, ph_c_s;
  logic [5:0] key_s;
  logic     gap_s, shoot_s, stable_s, accept_s, illegal_s, skip_set_s;
  sec_dec_t dec_s;

  motoro3_phase_decode u_dec_a (.gate_h(gate_q[5]), .gate_l(gate_q[4]), .state(ph_a_s));
  motoro3_phase_decode u_dec_b (.gate_h(gate_q[3]), .gate_l(gate_q[2]), .state(ph_b_s));
  motoro3_phase_decode u_dec_c (.gate_h(gate_q[1]), .gate_l(gate_q[0]), .state(ph_c_s));

  assign key_s   = {ph_a_s, ph_b_s, ph_c_s};
  assign gap_s   = (ph_a_s == PH_FLOAT) && (ph_b_s == PH_FLOAT) && (ph_c_s == PH_FLOAT);
  assign shoot_s = (ph_a_s == PH_SHOOT) || (ph_b_s == PH_SHOOT) || (ph_c_s == PH_SHOOT);
  assign dec_s   = decode_sector(ph_a_s, ph_b_s, ph_c_s);

  // Capture the raw gate pins; everything downstream sees only this sample.
  always_comb begin
    gate_d = {aH, aL, bH, bL, cH, cL};
  end

  // Deglitch: count consecutive identical non-gap samples; PWM-off gaps are transparent.
  always_comb begin
    last_key_d = last_key_q;
    dg_cnt_d   = dg_cnt_q;
    if (gap_s) begin
      last_key_d = last_key_q;
      dg_cnt_d   = dg_cnt_q;
    end else if (key_s == last_key_q) begin
      if (dg_cnt_q != DG_MAX) begin
        dg_cnt_d = dg_cnt_q + 4'd1;
      end else begin
        dg_cnt_d = DG_MAX;
      end
    end else begin
      last_key_d = key_s;
      dg_cnt_d   = 4'd1;
    end
  end

  assign stable_s  = !gap_s && (dg_cnt_d >= DG_TH);
  assign accept_s  = stable_s && dec_s.valid;
  assign illegal_s = stable_s && !dec_s.valid && !shoot_s;

  // Sector tracking, step classification and period measurement.
  always_comb begin
    sector_d   = sector_q;
    valid_d    = valid_q;
    dir_d      = dir_q;
    strobe_d   = 1'b0;
    period_d   = period_q;
    skip_set_s = 1'b0;
    if (!valid_q) begin
      per_cnt_d = {PERIOD_W{1'b0}};
    end else if (per_cnt_q == PER_MAX) begin
      per_cnt_d = PER_MAX;
    end else begin
      per_cnt_d = per_cnt_q + PER_ONE;
    end
    if (accept_s) begin
      if (!valid_q) begin
        // First sector after reset: no direction is known yet.
        valid_d   = 1'b1;
        sector_d  = dec_s.sec;
        per_cnt_d = PER_ONE;
      end else if (dec_s.sec == sector_q) begin
        sector_d = sector_q;
      end else if (dec_s.sec == sec_fwd(sector_q)) begin
        sector_d  = dec_s.sec;
        dir_d     = 1'b1;
        strobe_d  = 1'b1;
        period_d  = per_cnt_q;
        per_cnt_d = PER_ONE;
      end else if (dec_s.sec == sec_rev(sector_q)) begin
        sector_d  = dec_s.sec;
        dir_d     = 1'b0;
        strobe_d  = 1'b1;
        period_d  = per_cnt_q;
        per_cnt_d = PER_ONE;
      end else begin
        // Non-adjacent jump: resynchronise but do not report a step.
        sector_d   = dec_s.sec;
        skip_set_s = 1'b1;
        per_cnt_d  = PER_ONE;
      end
    end else begin
      strobe_d = 1'b0;
    end
    stall_d  = valid_d && (per_cnt_d == PER_MAX);
    pwm_on_d = !gap_s;
  end

  // Sticky faults; a new fault event wins over a simultaneous clear.
  always_comb begin
    if (shoot_s) begin
      flt_shoot_d = 1'b1;
    end else if (fltClr) begin
      flt_shoot_d = 1'b0;
    end else begin
      flt_shoot_d = flt_shoot_q;
    end
    if (illegal_s) begin
      flt_illegal_d = 1'b1;
    end else if (fltClr) begin
      flt_illegal_d = 1'b0;
    end else begin
      flt_illegal_d = flt_illegal_q;
    end
    if (skip_set_s) begin
      flt_skip_d = 1'b1;
    end else if (fltClr) begin
      flt_skip_d = 1'b0;
    end else begin
      flt_skip_d = flt_skip_q;
    end
  end

  // State register for the whole monitor.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      gate_q        <= 6'd0;
      last_key_q    <= 6'd0;
      dg_cnt_q      <= 4'd0;
      sector_q      <= SEC_0;
      valid_q       <= 1'b0;
      dir_q         <= 1'b0;
      strobe_q      <= 1'b0;
      period_q      <= {PERIOD_W{1'b0}};
      per_cnt_q     <= {PERIOD_W{1'b0}};
      pwm_on_q      <= 1'b0;
      stall_q       <= 1'b0;
      flt_shoot_q   <= 1'b0;
      flt_illegal_q <= 1'b0;
      flt_skip_q    <= 1'b0;
    end else begin
      gate_q        <= gate_d;
      last_key_q    <= last_key_d;
      dg_cnt_q      <= dg_cnt_d;
      sector_q      <= sector_d;
      valid_q       <= valid_d;
      dir_q         <= dir_d;
      strobe_q      <= strobe_d;
      period_q      <= period_d;
      per_cnt_q     <= per_cnt_d;
      pwm_on_q      <= pwm_on_d;
      stall_q       <= stall_d;
      flt_shoot_q   <= flt_shoot_d;
      flt_illegal_q <= flt_illegal_d;
      flt_skip_q    <= flt_skip_d;
    end
  end

  assign sector      = sector_q;
  assign sectorValid = valid_q;
  assign dir         = dir_q;
  assign stepStrobe  = strobe_q;
  assign stepPeriod  = period_q;
  assign pwmOn       = pwm_on_q;
  assign stall       = stall_q;
  assign fltShoot    = flt_shoot_q;
  assign fltIllegal  = flt_illegal_q;
  assign fltSkip     = flt_skip_q;

endmodule

// File: doc/motoro3_gate_monitor.md
MOTORO3_GATE_MONITOR -- requirements
Module: motoro3_gate_monitor

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL expose parameter PERIOD_W, default 20, step-period counter width in bits.
REQ-003 SHALL expose parameter DEGLITCH, default 2, number of consecutive identical samples required to accept a pattern (range 1..15).
REQ-004 SHALL have ports: clk  in  1  system clock (10 MHz).
REQ-005 SHALL have ports: Rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: aH, bH, cH  in  1 each  high-side gate drive, 1 = on.
REQ-007 SHALL have ports: aL, bL, cL  in  1 each  low-side gate drive, active-low (0 = on).
REQ-008 SHALL have ports: fltClr  in  1  clears all sticky fault flags.
REQ-009 SHALL have ports: sector  out  3  last accepted commutation sector, 0..5.
REQ-010 SHALL have ports: sectorValid  out  1  at least one sector accepted since reset.
REQ-011 SHALL have ports: dir  out  1  1 = forward, 0 = reverse, from last step.
REQ-012 SHALL have ports: stepStrobe  out  1  one-cycle pulse per accepted adjacent-sector step.
REQ-013 SHALL have ports: stepPeriod  out  PERIOD_W  clk cycles between the last two steps.
REQ-014 SHALL have ports: pwmOn  out  1  at least one phase is driven in the current registered sample.
REQ-015 SHALL have ports: stall, fltShoot, fltIllegal, fltSkip  out  1 each  status and fault flags.

Function
REQ-016 SHALL register all six gate inputs once; all decoding uses this registered sample.
REQ-017 SHALL decode each phase as HI (H=1, L=1), LO (H=0, L=0), FLOAT (H=0, L=1), or SHOOT (H=1, L=0).
REQ-018 SHALL set fltShoot at the edge after any phase is sampled as SHOOT, with no deglitch.
REQ-019 SHALL treat an all-FLOAT sample as the PWM-off gap: no sector change, no fault, and the deglitch counter unaffected.
REQ-020 SHALL define valid patterns as exactly one HI phase and one LO phase: A+B-=0, A+C-=1, B+C-=2, B+A-=3, C+A-=4, C+B-=5.
REQ-021 SHALL accept a valid pattern after DEGLITCH consecutive non-gap samples of that same pattern; sector and flags update on the edge of the DEGLITCH-th sample.
REQ-022 SHALL set fltIllegal when any non-gap, non-SHOOT, non-valid pattern persists for DEGLITCH samples.
REQ-023 SHALL, on the first accepted sector after reset, set sectorValid, load sector, and restart the period counter, with no stepStrobe and no dir update.
REQ-024 SHALL treat an accepted sector equal to the current sector as no event.
REQ-025 SHALL treat new = (old+1) mod 6 as a forward step: dir=1, stepStrobe=1, stepPeriod loaded, counter restarts at 1.
REQ-026 SHALL treat new = (old+5) mod 6 as a reverse step: dir=0, with the same strobe and period behaviour as REQ-025.
REQ-027 SHALL treat any other sector change as a skip: load sector, set fltSkip, restart the counter, and leave stepStrobe, dir, and stepPeriod unchanged.
REQ-028 SHALL increment the period counter every cycle once sectorValid is set, saturating at all-ones.
REQ-029 SHALL set stall while the counter is saturated, and clear it on the next step or skip.
REQ-030 SHALL clear the fault flags on fltClr; a fault set event in the same cycle overrides the clear.

Reset
REQ-031 SHALL, on reset, force the following outputs to 0: sector, sectorValid, dir, stepStrobe, stepPeriod, pwmOn, stall, and all fault flags.
REQ-032 SHALL also clear the input register, deglitch counter, and period counter on reset.
REQ-033 SHALL, on reset asserted mid-operation, discard any partially deglitched pattern; after release, the first accepted sector follows REQ-023.

Structure
REQ-034 SHALL place the phase-state encoding (HI/LO/FLOAT/SHOOT) and the sector constants 0..5 in shared package motoro3_pkg.
REQ-035 SHALL implement per-phase decoding in sub-module motoro3_phase_decode, instantiated three times.
REQ-036 SHALL make every output a registered output.

Verification
REQ-037 SHALL cover: reset, then pattern aH=1, bL=0 for 4 cycles -> sector=0 and sectorValid=1 two edges after the first sample; stepStrobe=0.
REQ-038 SHALL cover: sectors 0->1->2 with 1000 cycles per step and 1-cycle all-FLOAT gaps -> stepStrobe twice, dir=1, stepPeriod=1000.
REQ-039 SHALL cover: sector 3 then sector 2 -> dir=0 and stepStrobe; then sector 2 then sector 5 -> fltSkip=1, with stepStrobe and dir unchanged.
REQ-040 SHALL cover: aH=1 with aL=0 for 1 cycle -> fltShoot=1; fltClr held 1 while the fault is still present -> fltShoot stays 1.
REQ-041 SHALL cover: a 1-cycle glitch to sector 4 inside sector 0 with DEGLITCH=2 -> no change; no step for 2^20 cycles -> stall=1 and stepPeriod unchanged.
REQ-042 SHALL cover: Rst pulsed mid-step -> all outputs 0; the next sector is accepted as first, without stepStrobe.
